// File: rtl/float_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (16/32/64-bit) with valid/ready on both sides.
// Define FLOAT_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module float_mul_pipe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] c,
    output logic [3:0]            flags
);
    localparam int EXP_W = (DATA_WIDTH == 16) ? 5 : (DATA_WIDTH == 64) ? 11 : 8;
    localparam int MAN_W = DATA_WIDTH - EXP_W - 1;
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int PW    = 2 * MAN_W + 2;

    localparam logic [EXP_W+1:0]        BIAS_V = (EXP_W + 2)'(BIAS);
    localparam logic signed [EXP_W+2:0] E_MAX  = (EXP_W + 3)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+2:0] E_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0]   QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    generate
        if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("float_mul_pipe: DATA_WIDTH must be 16, 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {K_NORM, K_NAN, K_INF, K_ZERO} kind_t;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operand unpack and classification (subnormals flushed to zero)
    logic [DATA_WIDTH-1:0] op      [2];
    logic [EXP_W-1:0]      op_exp  [2];
    logic [MAN_W-1:0]      op_man  [2];
    logic                  op_zero [2];
    logic                  op_inf  [2];
    logic                  op_nan  [2];
    logic                  op_snan [2];

    assign op[0] = a;
    assign op[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_exp[gi]  = op[gi][DATA_WIDTH-2 -: EXP_W];
            assign op_man[gi]  = op[gi][MAN_W-1:0];
            assign op_zero[gi] = (op_exp[gi] == '0);
            assign op_inf[gi]  = (&op_exp[gi]) && (op_man[gi] == '0);
            assign op_nan[gi]  = (&op_exp[gi]) && (op_man[gi] != '0);
            assign op_snan[gi] = op_nan[gi] && !op_man[gi][MAN_W-1];
        end
    endgenerate

    // Stage 1 next values
    kind_t            s1_kind_next;
    logic             s1_nv_next;
    logic             inf_zero;
    logic [EXP_W+1:0] s1_esum_next;

    assign inf_zero     = (op_inf[0] && op_zero[1]) || (op_inf[1] && op_zero[0]);
    assign s1_esum_next = {2'b00, op_exp[0]} + {2'b00, op_exp[1]} - BIAS_V;

    always_comb begin
        s1_kind_next = K_NORM;
        s1_nv_next   = 1'b0;
        if (op_nan[0] || op_nan[1] || inf_zero) begin
            s1_kind_next = K_NAN;
            s1_nv_next   = op_snan[0] || op_snan[1] || inf_zero;
        end else if (op_inf[0] || op_inf[1]) begin
            s1_kind_next = K_INF;
        end else if (op_zero[0] || op_zero[1]) begin
            s1_kind_next = K_ZERO;
        end
    end

    logic                    s1_valid_reg, s2_valid_reg;
    logic                    s1_sign_reg, s2_sign_reg;
    kind_t                   s1_kind_reg, s2_kind_reg;
    logic                    s1_nv_reg, s2_nv_reg;
    logic signed [EXP_W+1:0] s1_esum_reg, s2_esum_reg;
    logic [MAN_W-1:0]        s1_ma_reg, s1_mb_reg;
    logic [PW-1:0]           s2_prod_reg;
    logic [PW-1:0]           s2_prod_next;
    logic [DATA_WIDTH-1:0]   c_reg, c_next;
    logic [3:0]              flags_reg, flags_next;
    logic                    out_valid_reg;

    assign s2_prod_next = PW'({1'b1, s1_ma_reg}) * PW'({1'b1, s1_mb_reg});

    // Stage 3: normalise, round, pack, then let special operands override
    logic                    prod_msb, guard, sticky, inc;
    logic [PW-2:0]           win;
    logic [MAN_W-1:0]        man_t;
    logic [MAN_W:0]          man_r;
    logic signed [EXP_W+2:0] e_n, e_f;

    always_comb begin
        prod_msb   = s2_prod_reg[PW-1];
        win        = prod_msb ? s2_prod_reg[PW-2:0] : {s2_prod_reg[PW-3:0], 1'b0};
        man_t      = win[PW-2 -: MAN_W];
        guard      = win[MAN_W];
        sticky     = |win[MAN_W-1:0];
`ifdef FLOAT_MUL_RNE_EN
        inc        = guard && (sticky || man_t[0]);
`else
        inc        = 1'b0;
`endif
        man_r      = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
        e_n        = {s2_esum_reg[EXP_W+1], s2_esum_reg} + {{(EXP_W+2){1'b0}}, prod_msb};
        e_f        = e_n + {{(EXP_W+2){1'b0}}, man_r[MAN_W]};
        c_next     = {s2_sign_reg, e_f[EXP_W-1:0], man_r[MAN_W-1:0]};
        flags_next = {3'b000, guard | sticky};
        if (e_f >= E_MAX) begin
`ifdef FLOAT_MUL_RNE_EN
            c_next = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
            c_next = {s2_sign_reg, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`endif
            flags_next = 4'b0101;
        end else if (e_f <= E_ZERO) begin
            c_next     = {s2_sign_reg, {(DATA_WIDTH-1){1'b0}}};
            flags_next = 4'b0011;
        end
        case (s2_kind_reg)
            K_NAN: begin
                c_next     = QNAN;
                flags_next = {s2_nv_reg, 3'b000};
            end
            K_INF: begin
                c_next     = {s2_sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_next = 4'b0000;
            end
            K_ZERO: begin
                c_next     = {s2_sign_reg, {(DATA_WIDTH-1){1'b0}}};
                flags_next = 4'b0000;
            end
            default: ;
        endcase
    end

    // All stages advance together; a stalled consumer freezes the whole pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_sign_reg   <= 1'b0;
            s1_kind_reg   <= K_NORM;
            s1_nv_reg     <= 1'b0;
            s1_esum_reg   <= '0;
            s1_ma_reg     <= '0;
            s1_mb_reg     <= '0;
            s2_valid_reg  <= 1'b0;
            s2_sign_reg   <= 1'b0;
            s2_kind_reg   <= K_NORM;
            s2_nv_reg     <= 1'b0;
            s2_esum_reg   <= '0;
            s2_prod_reg   <= '0;
            out_valid_reg <= 1'b0;
            c_reg         <= '0;
            flags_reg     <= '0;
        end else if (adv) begin
            s1_valid_reg  <= in_valid;
            s1_sign_reg   <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
            s1_kind_reg   <= s1_kind_next;
            s1_nv_reg     <= s1_nv_next;
            s1_esum_reg   <= s1_esum_next;
            s1_ma_reg     <= op_man[0];
            s1_mb_reg     <= op_man[1];
            s2_valid_reg  <= s1_valid_reg;
            s2_sign_reg   <= s1_sign_reg;
            s2_kind_reg   <= s1_kind_reg;
            s2_nv_reg     <= s1_nv_reg;
            s2_esum_reg   <= s1_esum_reg;
            s2_prod_reg   <= s2_prod_next;
            out_valid_reg <= s2_valid_reg;
            c_reg         <= c_next;
            flags_reg     <= flags_next;
        end
    end

    assign out_valid = out_valid_reg;
    assign c         = c_reg;
    assign flags     = flags_reg;
endmodule
